// File: rtl/lcd_ci_sequencer_if.sv
// lcd_ci_sequencer_if: custom-instruction handshake between the Nios II core (master) and the LCD sequencer (slave).
interface lcd_ci_sequencer_if;
   logic        clk_en;
   logic        start;
   logic        done;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic [31:0] result;
   modport master (output clk_en, start, dataa, datab, input result, done);
   modport slave (input clk_en, start, dataa, datab, output result, done);
endinterface

// File: rtl/lcd_ci_sequencer.sv
// lcd_ci_sequencer: Nios II custom-instruction HD44780 write sequencer with backlight and illegal-opcode return.
// Define LCD_NIBBLE_EN for 4-bit bus mode (high nibble then low nibble on db[7:4]).
module lcd_ci_sequencer #(
   parameter int SETUP_CYC     = 4,
   parameter int EN_HIGH_CYC   = 25,
   parameter int HOLD_CYC      = 25,
   parameter int EXEC_CYC      = 2000,
   parameter int LONG_EXEC_CYC = 82000,
   parameter int CNT_W         = 17
) (
   input  logic              clk,
   input  logic              reset,
   lcd_ci_sequencer_if.slave ci,
   output logic              bl,
   output logic              rs,
   output logic              rw,
   output logic              en,
   output logic [7:0]        db
);
   typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC, DONE} state_t;
   localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] C_EN    = CNT_W'(EN_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] C_EXEC  = CNT_W'(EXEC_CYC - 1);
   localparam logic [CNT_W-1:0] C_LONG  = CNT_W'(LONG_EXEC_CYC - 1);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      pay_q, pay_d, result_q, result_d;
   logic [1:0]       left_q, left_d;
   logic [2:0]       tot_q, tot_d;
   logic             done_q, done_d, bl_q, bl_d, rs_q, rs_d, en_q, en_d;
   logic [7:0]       db_q, db_d;
   logic             long_exec;
   logic             unused;
   // Clear (0x01) and home (0x02/0x03) need the long execution wait.
   assign long_exec = !rs_q && pay_q[7:2] == 6'd0 && pay_q[1:0] != 2'd0;
   assign unused = ^ci.dataa[31:5];
`ifdef LCD_NIBBLE_EN
   logic lo_q, lo_d;
   function automatic logic [7:0] bus(input logic [7:0] b);
      return b & 8'hF0;
   endfunction
`else
   function automatic logic [7:0] bus(input logic [7:0] b);
      return b;
   endfunction
`endif
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pay_d    = pay_q;
      result_d = result_q;
      left_d   = left_q;
      tot_d    = tot_q;
      done_d   = done_q;
      bl_d     = bl_q;
      rs_d     = rs_q;
      en_d     = en_q;
      db_d     = db_q;
`ifdef LCD_NIBBLE_EN
      lo_d     = lo_q;
`endif
      if (ci.clk_en) begin
         done_d = 1'b0;
         case (state_q)
            IDLE: if (ci.start) begin
               pay_d  = ci.datab;
               left_d = ci.dataa[2:0] == 3'd2 ? ci.dataa[4:3] : 2'd0;
               tot_d  = {1'b0, left_d} + 3'd1;
               if (ci.dataa[2:0] <= 3'd2) begin
                  rs_d    = ci.dataa[2:0] != 3'd0;
                  db_d    = bus(ci.datab[7:0]);
                  cnt_d   = C_SETUP;
                  state_d = SETUP;
               end else begin
                  bl_d     = ci.dataa[2:0] == 3'd3 ? ci.datab[0] : bl_q;
                  result_d = ci.dataa[2:0] == 3'd3 ? 32'd0 : 32'hFFFF_FFFF;
                  done_d   = 1'b1;
                  state_d  = DONE;
               end
            end
            SETUP: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
               else begin
                  en_d    = 1'b1;
                  cnt_d   = C_EN;
                  state_d = PULSE;
               end
            PULSE: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
               else begin
                  en_d    = 1'b0;
                  cnt_d   = C_HOLD;
                  state_d = HOLD;
               end
            HOLD: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
`ifdef LCD_NIBBLE_EN
               else if (!lo_q) begin
                  lo_d    = 1'b1;
                  db_d    = {pay_q[3:0], 4'h0};
                  cnt_d   = C_SETUP;
                  state_d = SETUP;
               end
`endif
               else begin
`ifdef LCD_NIBBLE_EN
                  lo_d    = 1'b0;
`endif
                  db_d    = 8'd0;
                  cnt_d   = long_exec ? C_LONG : C_EXEC;
                  state_d = EXEC;
               end
            EXEC: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
               else if (left_q != 2'd0) begin
                  left_d  = left_q - 2'd1;
                  pay_d   = pay_q >> 8;
                  db_d    = bus(pay_q[15:8]);
                  cnt_d   = C_SETUP;
                  state_d = SETUP;
               end else begin
                  result_d = {29'd0, tot_q};
                  done_d   = 1'b1;
                  state_d  = DONE;
               end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pay_q    <= '0;
         result_q <= '0;
         left_q   <= '0;
         tot_q    <= '0;
         done_q   <= 1'b0;
         bl_q     <= 1'b0;
         rs_q     <= 1'b0;
         en_q     <= 1'b0;
         db_q     <= '0;
`ifdef LCD_NIBBLE_EN
         lo_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pay_q    <= pay_d;
         result_q <= result_d;
         left_q   <= left_d;
         tot_q    <= tot_d;
         done_q   <= done_d;
         bl_q     <= bl_d;
         rs_q     <= rs_d;
         en_q     <= en_d;
         db_q     <= db_d;
`ifdef LCD_NIBBLE_EN
         lo_q     <= lo_d;
`endif
      end
   end
   assign ci.done   = done_q;
   assign ci.result = result_q;
   assign bl = bl_q;
   assign rs = rs_q;
   assign rw = 1'b0;
   assign en = en_q;
   assign db = db_q;
endmodule
